// File: rtl/pong_pkg.sv
// Shared PONG constants: screen-mode codes, menu/options row codes, reset speed and score layout.
package pong_pkg;

  localparam int unsigned MODE_W      = 3;
  localparam int unsigned ROW_W       = 2;
  localparam int unsigned SPEED_W     = 2;
  localparam int unsigned NIB_W       = 4;
  localparam int unsigned SCORE_W     = 2 * NIB_W;
  localparam int unsigned FRAME_CNT_W = 9;

  localparam logic [MODE_W-1:0] SCR_MENU    = 3'b000;
  localparam logic [MODE_W-1:0] SCR_GAME    = 3'b001;
  localparam logic [MODE_W-1:0] SCR_CREDITS = 3'b010;
  localparam logic [MODE_W-1:0] SCR_OPTIONS = 3'b011;
  localparam logic [MODE_W-1:0] SCR_P1_WIN  = 3'b100;
  localparam logic [MODE_W-1:0] SCR_P2_WIN  = 3'b101;

  localparam logic [ROW_W-1:0] ROW_START   = 2'd0;
  localparam logic [ROW_W-1:0] ROW_OPTIONS = 2'd1;
  localparam logic [ROW_W-1:0] ROW_CREDITS = 2'd2;
  localparam logic [ROW_W-1:0] ROW_SPEED   = 2'd0;
  localparam logic [ROW_W-1:0] ROW_BACK    = 2'd1;

  localparam logic [SPEED_W-1:0] SPEED_RST = 2'd1;

  typedef struct packed {
    logic [NIB_W-1:0] left;
    logic [NIB_W-1:0] right;
  } score_t;

  // Three-row menu cursor step with wrap in both directions.
  function automatic logic [ROW_W-1:0] menu_row_step(input logic [ROW_W-1:0] row,
                                                     input logic             down);
    logic [ROW_W-1:0] nxt;
    if (down) nxt = (row >= ROW_CREDITS) ? ROW_START : ROW_W'(row + ROW_W'(1));
    else      nxt = (row == ROW_START) ? ROW_CREDITS : ROW_W'(row - ROW_W'(1));
    return nxt;
  endfunction

endpackage

// File: rtl/pong_mode_ctrl_if.sv
// Button/point inputs and screen-selection outputs between PONG input logic and the mode controller.
interface pong_mode_ctrl_if;
  import pong_pkg::*;

  logic                btn_up;
  logic                btn_down;
  logic                btn_select;
  logic                btn_back;
  logic                point_left;
  logic                point_right;
  logic                frame_tick;
  logic [MODE_W-1:0]   screen_mode;
  logic [ROW_W-1:0]    icon_highlighter;
  logic [SPEED_W-1:0]  speed_selector;
  logic [SCORE_W-1:0]  score;
  logic                game_start;

  modport master (
    output btn_up, btn_down, btn_select, btn_back, point_left, point_right, frame_tick,
    input  screen_mode, icon_highlighter, speed_selector, score, game_start
  );

  modport slave (
    input  btn_up, btn_down, btn_select, btn_back, point_left, point_right, frame_tick,
    output screen_mode, icon_highlighter, speed_selector, score, game_start
  );

endinterface

// File: rtl/pong_mode_ctrl_btn_edge.sv
// Rising-edge detector on a debounced button level; history register plus combinational pulse.
module btn_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  // Tracking the live level through reset means a button held across reset reads as already seen.
  always_ff @(posedge clk_in) begin
    level_q <= level;
  end

  assign rise_c = level & ~level_q & ~rst;

endmodule

// File: rtl/pong_mode_ctrl.sv
// PONG menu/game sequencer driving the VGA screen selection buses.
// Optional winner-screen auto-return is built when PONG_WIN_TIMEOUT_EN is defined.
module pong_mode_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE      = 9,
  parameter int unsigned TIMEOUT_FRAMES = 300
) (
  input  logic            clk_in,
  input  logic            rst,
  pong_mode_ctrl_if.slave bus
);

  logic up_c, down_c, sel_c, back_c;
  logic act_up_c, act_down_c, act_sel_c, act_back_c;
  logic win_c, timeout_c;

  logic [MODE_W-1:0]  state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  score_t             score_q, score_d;
  logic               start_q, start_d;
  logic [NIB_W-1:0]   left_inc_c, right_inc_c;

  btn_edge u_edge_up   (.clk_in(clk_in), .rst(rst), .level(bus.btn_up),     .rise_c(up_c));
  btn_edge u_edge_down (.clk_in(clk_in), .rst(rst), .level(bus.btn_down),   .rise_c(down_c));
  btn_edge u_edge_sel  (.clk_in(clk_in), .rst(rst), .level(bus.btn_select), .rise_c(sel_c));
  btn_edge u_edge_back (.clk_in(clk_in), .rst(rst), .level(bus.btn_back),   .rise_c(back_c));

  // One button per cycle: back > select > up > down.
  assign act_back_c = back_c;
  assign act_sel_c  = sel_c & ~back_c;
  assign act_up_c   = up_c & ~sel_c & ~back_c;
  assign act_down_c = down_c & ~up_c & ~sel_c & ~back_c;

  assign win_c       = (state_q == SCR_P1_WIN) || (state_q == SCR_P2_WIN);
  assign left_inc_c  = NIB_W'(score_q.left + NIB_W'(1));
  assign right_inc_c = NIB_W'(score_q.right + NIB_W'(1));

`ifdef PONG_WIN_TIMEOUT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Counter idles at zero outside the winner screens, so it starts fresh on each entry.
  always_comb begin
    frame_cnt_d = '0;
    timeout_c   = 1'b0;
    if (win_c) begin
      frame_cnt_d = frame_cnt_q;
      if (bus.frame_tick) begin
        frame_cnt_d = FRAME_CNT_W'(frame_cnt_q + FRAME_CNT_W'(1));
        timeout_c   = (frame_cnt_q == FRAME_CNT_W'(TIMEOUT_FRAMES - 1));
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end
`else
  logic unused_timeout;
  assign timeout_c      = 1'b0;
  assign unused_timeout = ^{bus.frame_tick, FRAME_CNT_W'(TIMEOUT_FRAMES)};
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    speed_d = speed_q;
    score_d = score_q;
    start_d = 1'b0;
    case (state_q)
      SCR_MENU: begin
        if (act_sel_c) begin
          case (row_q)
            ROW_START: begin
              state_d = SCR_GAME;
              score_d = '0;
              start_d = 1'b1;
            end
            ROW_OPTIONS: begin
              state_d = SCR_OPTIONS;
              row_d   = ROW_SPEED;
            end
            ROW_CREDITS: state_d = SCR_CREDITS;
            default:     row_d   = ROW_START;
          endcase
        end else if (act_up_c) begin
          row_d = menu_row_step(row_q, 1'b0);
        end else if (act_down_c) begin
          row_d = menu_row_step(row_q, 1'b1);
        end
      end
      SCR_OPTIONS: begin
        if (act_back_c || (act_sel_c && (row_q == ROW_BACK))) begin
          state_d = SCR_MENU;
          row_d   = ROW_OPTIONS;
        end else if (act_sel_c) begin
          speed_d = SPEED_W'(speed_q + SPEED_W'(1));
        end else if (act_up_c || act_down_c) begin
          row_d = (row_q == ROW_SPEED) ? ROW_BACK : ROW_SPEED;
        end
      end
      SCR_CREDITS: begin
        if (act_back_c || act_sel_c) begin
          state_d = SCR_MENU;
          row_d   = ROW_CREDITS;
        end
      end
      SCR_GAME: begin
        if (act_back_c) begin
          state_d = SCR_MENU;
          row_d   = ROW_START;
          score_d = '0;
        end else if (bus.point_left) begin
          score_d.left = left_inc_c;
          if (left_inc_c == NIB_W'(WIN_SCORE)) state_d = SCR_P1_WIN;
        end else if (bus.point_right) begin
          score_d.right = right_inc_c;
          if (right_inc_c == NIB_W'(WIN_SCORE)) state_d = SCR_P2_WIN;
        end
      end
      SCR_P1_WIN, SCR_P2_WIN: begin
        if (act_back_c || act_sel_c || timeout_c) begin
          state_d = SCR_MENU;
          row_d   = ROW_START;
          score_d = '0;
        end
      end
      default: begin
        state_d = SCR_MENU;
        row_d   = ROW_START;
        score_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= SCR_MENU;
      row_q   <= ROW_START;
      speed_q <= SPEED_RST;
      score_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      speed_q <= speed_d;
      score_q <= score_d;
      start_q <= start_d;
    end
  end

  assign bus.screen_mode      = state_q;
  assign bus.icon_highlighter = row_q;
  assign bus.speed_selector   = speed_q;
  assign bus.score            = score_q;
  assign bus.game_start       = start_q;

endmodule
